// File: rtl/cim_sched.sv
// cim_sched: periodic sample scheduler and frame-tagging FIFO for the CIM integrator chain.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable, period      run request and sample interval (latched when leaving IDLE)
//   sample              one-cycle snapshot strobe to the integrator chain
//   sr_out, sr_val      shift-out words returned by the chain
//   buf_data/first/valid, buf_ready   show-ahead FIFO head and consumer pop
//   frame_done          pulse after the last word of a frame is taken
//   overrun, frame_err  sticky error flags, cleared by err_clr
module cim_sched #(
  parameter int dw    = 32,
  parameter int nword = 34,
  parameter int pw    = 16,
  parameter int aw    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [pw-1:0] period,
  output logic          sample,
  input  logic [dw-1:0] sr_out,
  input  logic          sr_val,
  output logic [dw-1:0] buf_data,
  output logic          buf_first,
  output logic          buf_valid,
  input  logic          buf_ready,
  output logic          frame_done,
  output logic          overrun,
  output logic          frame_err,
  input  logic          err_clr
);
  localparam int cw = $clog2(nword + 1);
  localparam int depth = 1 << aw;
  localparam logic [pw-1:0] minp = pw'(nword + 2);
  localparam logic [cw-1:0] lastw = cw'(nword - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q;
  logic [pw-1:0] pcnt_q, rld_q, rld_d;
  logic [cw-1:0] wcnt_q;
  logic          sample_q, open_q, frame_done_q, overrun_q, frame_err_q;
  logic [aw:0]   wr_q, rd_q;
  logic [dw:0]   mem_q [depth];
  logic [dw:0]   head;
  logic          push, pop, full, empty, wr_en, last;

  // The period never drops below one full frame plus turnaround.
  assign rld_d = (period < minp ? minp : period) - pw'(1);

  assign push  = sr_val && open_q;
  assign last  = wcnt_q == lastw;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q - rd_q) == {1'b1, {aw{1'b0}}};
  assign pop   = !empty && buf_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign head  = mem_q[rd_q[aw-1:0]];

  assign sample     = sample_q;
  assign buf_valid  = !empty;
  assign buf_data   = empty ? '0 : head[dw-1:0];
  assign buf_first  = !empty && head[dw];
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[aw-1:0]] <= {wcnt_q == '0, sr_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      rld_q        <= '0;
      sample_q     <= 1'b0;
      wcnt_q       <= '0;
      open_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
    end else begin
      sample_q <= 1'b0;
      case (state_q)
        IDLE: if (enable) begin
          state_q <= RUN;
          rld_q   <= rld_d;
          pcnt_q  <= rld_d;
        end
        // A strobe already on the wire counts as an open frame for draining.
        RUN: if (!enable) state_q <= (open_q || sample_q) ? DRAIN : IDLE;
        else if (pcnt_q == '0) begin
          pcnt_q   <= rld_q;
          sample_q <= 1'b1;
        end else pcnt_q <= pcnt_q - pw'(1);
        DRAIN: if (!open_q && !sample_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (push) wcnt_q <= wcnt_q + cw'(1);
      if (push && last) open_q <= 1'b0;
      // A new strobe always restarts the frame, even over an unfinished one.
      if (sample_q) begin
        wcnt_q <= '0;
        open_q <= 1'b1;
      end
      frame_done_q <= push && last;
      if (wr_en) wr_q <= wr_q + (aw+1)'(1);
      if (pop) rd_q <= rd_q + (aw+1)'(1);
      overrun_q   <= (push && full && !pop) || (overrun_q && !err_clr);
      frame_err_q <= (sr_val && !open_q) || (sample_q && open_q) || (frame_err_q && !err_clr);
    end
  end
endmodule
